// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: sequencer states,
// read-latency legality and byte-lane width derivation.
package dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned LANE_W           = 8;
  localparam int unsigned MIN_READ_LATENCY = 1;
  localparam int unsigned MAX_READ_LATENCY = 2;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / LANE_W;
  endfunction

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/dpram_core.sv
// Dual-port storage array with byte-lane writes, A-over-B lane priority on
// same-address writes, and one registered read stage per port.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_wr_i,
  input  logic                          a_rd_i,
  input  logic [be_width(DATA_W)-1:0]   a_be_i,
  input  logic [ADDR_W-1:0]             a_addr_i,
  input  logic [DATA_W-1:0]             a_din_i,
  output logic [DATA_W-1:0]             a_dout_o,
  input  logic                          b_wr_i,
  input  logic                          b_rd_i,
  input  logic [be_width(DATA_W)-1:0]   b_be_i,
  input  logic [ADDR_W-1:0]             b_addr_i,
  input  logic [DATA_W-1:0]             b_din_i,
  output logic [DATA_W-1:0]             b_dout_o
);

  localparam int unsigned BE_W  = be_width(DATA_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_old_c, a_merge_c, b_old_c, b_merge_c;
  logic [DATA_W-1:0] a_dout_q, b_dout_q;

  // Pre-write word and this port's own lane-merged word, for read-during-write
  always_comb begin
    a_old_c   = mem_q[a_addr_i];
    b_old_c   = mem_q[b_addr_i];
    a_merge_c = a_old_c;
    b_merge_c = b_old_c;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (a_be_i[i]) a_merge_c[i*LANE_W +: LANE_W] = a_din_i[i*LANE_W +: LANE_W];
      if (b_be_i[i]) b_merge_c[i*LANE_W +: LANE_W] = b_din_i[i*LANE_W +: LANE_W];
    end
  end

  // B lanes land first so an A write to the same lane overrides it
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (b_wr_i && b_be_i[i]) mem_q[b_addr_i][i*LANE_W +: LANE_W] <= b_din_i[i*LANE_W +: LANE_W];
      if (a_wr_i && a_be_i[i]) mem_q[a_addr_i][i*LANE_W +: LANE_W] <= a_din_i[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      if (a_rd_i) a_dout_q <= ((WRITE_FIRST != 0) && a_wr_i) ? a_merge_c : a_old_c;
      if (b_rd_i) b_dout_q <= ((WRITE_FIRST != 0) && b_wr_i) ? b_merge_c : b_old_c;
    end
  end

  assign a_dout_o = a_dout_q;
  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/dpram_pipe.sv
// Parametrised true dual-port RAM: post-reset clear sequencer, access gating,
// optional second read stage and same-address write-write collision flag.
module dpram_pipe
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          wea,
  input  logic [be_width(DATA_W)-1:0]   bea,
  input  logic [ADDR_W-1:0]             addra,
  input  logic [DATA_W-1:0]             dina,
  output logic [DATA_W-1:0]             douta,
  output logic                          valida,
  input  logic                          enb,
  input  logic                          web,
  input  logic [be_width(DATA_W)-1:0]   beb,
  input  logic [ADDR_W-1:0]             addrb,
  input  logic [DATA_W-1:0]             dinb,
  output logic [DATA_W-1:0]             doutb,
  output logic                          validb,
  output logic                          init_busy,
  output logic                          collision
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("dpram_pipe: READ_LATENCY must be 1 or 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              init_busy_q, vld_a_q, vld_b_q, coll_q;

  logic                        a_wr_c, a_rd_c, b_wr_c, b_rd_c, coll_c;
  logic [be_width(DATA_W)-1:0] a_be_c, b_be_c;
  logic [ADDR_W-1:0]           a_addr_c, b_addr_c;
  logic [DATA_W-1:0]           a_din_c, b_din_c;
  logic [DATA_W-1:0]           core_douta, core_doutb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // Clear borrows port A as a full-word zero write; user traffic waits for READY
  always_comb begin
    a_wr_c   = 1'b0;
    a_rd_c   = 1'b0;
    a_be_c   = '0;
    a_addr_c = addra;
    a_din_c  = dina;
    b_wr_c   = 1'b0;
    b_rd_c   = 1'b0;
    b_be_c   = '0;
    b_addr_c = addrb;
    b_din_c  = dinb;
    coll_c   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_CLEAR: begin
          a_wr_c   = 1'b1;
          a_be_c   = '1;
          a_addr_c = ptr_q;
          a_din_c  = '0;
        end
        ST_READY: begin
          a_wr_c = ena && wea;
          a_rd_c = ena;
          a_be_c = bea;
          b_wr_c = enb && web;
          b_rd_c = enb;
          b_be_c = beb;
          coll_c = ena && wea && enb && web && (addra == addrb);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_busy_q <= (CLEAR_ON_RESET != 0);
      vld_a_q     <= 1'b0;
      vld_b_q     <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      init_busy_q <= (state_d == ST_CLEAR);
      vld_a_q     <= a_rd_c;
      vld_b_q     <= b_rd_c;
      coll_q      <= coll_c;
    end
  end

  dpram_core #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .a_wr_i   (a_wr_c),
    .a_rd_i   (a_rd_c),
    .a_be_i   (a_be_c),
    .a_addr_i (a_addr_c),
    .a_din_i  (a_din_c),
    .a_dout_o (core_douta),
    .b_wr_i   (b_wr_c),
    .b_rd_i   (b_rd_c),
    .b_be_i   (b_be_c),
    .b_addr_i (b_addr_c),
    .b_din_i  (b_din_c),
    .b_dout_o (core_doutb)
  );

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] douta_q, doutb_q;
    logic              valida_q, validb_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        douta_q  <= '0;
        doutb_q  <= '0;
        valida_q <= 1'b0;
        validb_q <= 1'b0;
      end else begin
        valida_q <= vld_a_q;
        validb_q <= vld_b_q;
        if (vld_a_q) douta_q <= core_douta;
        if (vld_b_q) doutb_q <= core_doutb;
      end
    end

    assign douta  = douta_q;
    assign doutb  = doutb_q;
    assign valida = valida_q;
    assign validb = validb_q;
  end else begin : g_lat1
    assign douta  = core_douta;
    assign doutb  = core_doutb;
    assign valida = vld_a_q;
    assign validb = vld_b_q;
  end

  assign init_busy = init_busy_q;
  assign collision = coll_q;

endmodule
